instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage of the non-pipelined LEGv8 core. Owns the PC and runs a req/ack
//  handshake with instruction memory. Holds the fetched word in an instruction
//  register that feeds decode (sign extender, control, regfile). Computes the
//  next PC from the retire handshake and the sign-extended branch offset.
// PARAMETERS
//  WORD       64   datapath / PC width (`WORD)
//  INSTR_LEN  32   instruction width (`INSTR_LEN)
//  RESET_PC   0    PC loaded on reset
//  TIMEOUT    15   max cycles waiting for imem_ack before fault (>=1)
// PORTS
//  clk            in   1          core clock, all state on rising edge
//  reset_n        in   1          synchronous, active-low reset
//  imem_req       out  1          fetch request to instruction memory
//  imem_addr      out  WORD       fetch address; stable while imem_req=1
//  imem_ack       in   1          memory returns imem_rdata this cycle
//  imem_rdata     in   INSTR_LEN  fetched instruction word
//  instruction    out  INSTR_LEN  instruction register, to decode
//  pc_out         out  WORD       address of current instruction
//  instr_valid    out  1          instruction/pc_out hold a live instruction
//  instr_ready    in   1          core finished current instruction (retire)
//  branch_taken   in   1          redirect; sampled only with instr_ready
//  branch_offset  in   WORD       sign-extended word offset from sign extender
//  fetch_err      out  1          sticky fault: imem_ack timeout
//  instr_count    out  WORD       retired-instruction counter
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): state=FETCH, pc=RESET_PC, imem_req=0,
//   imem_addr=RESET_PC, instruction=0, pc_out=0, instr_valid=0, fetch_err=0,
//   instr_count=0, timer=0. imem_ack in a reset cycle is ignored.
//  States: FETCH, HOLD, FAULT.
//  FETCH: imem_req=1, imem_addr=pc. The first cycle after reset deasserts
//   has imem_req=1.
//   - imem_ack=1: instruction<=imem_rdata, pc_out<=pc, instr_valid<=1,
//     imem_req<=0, timer<=0, go HOLD.
//   - else timer++. When timer reaches TIMEOUT with no ack: fetch_err<=1,
//     imem_req<=0, go FAULT.
//   - Ack in the same cycle the timer would expire: ack wins, no fault.
//   - instr_ready/branch_taken are ignored in FETCH.
//  HOLD: imem_req=0; instruction/pc_out held stable for decode.
//   imem_ack is ignored.
//   - instr_ready=1: instr_valid<=0, instr_count<=instr_count+1.
//     pc <= branch_taken ? pc_out + (branch_offset<<2) : pc_out + 4.
//     Go FETCH.
//   - Arithmetic is modulo 2^WORD: wrap-around is silent. Negative offsets
//     come from two's complement.
//   - The target's low 2 bits are always 00 by construction.
//  FAULT: absorbing; all outputs hold, imem_req=0. Only reset exits.
//  Latency: ack-to-instr_valid 1 cycle. Retire-to-next imem_req 1 cycle.
//   Minimum 2 cycles per instruction with single-cycle memory.
//  Reset mid-fetch or mid-hold aborts immediately; no partial update.
//  instr_count wraps from 2^WORD-1 to 0.
// TESTING
//  1. Reset, imem_ack=1 every req, rdata=0x8B020020, instr_ready
//     1 cycle after valid -> imem_addr 0,4,8,...; instruction=0x8B020020;
//     instr_count increments per retire.
//  2. Retire at pc_out=0x40 with branch_taken=1, branch_offset=-4
//     (0xFFFF_FFFF_FFFF_FFFC) -> next imem_addr=0x30.
//  3. ack delayed 3 cycles -> imem_addr held at same value, imem_req=1
//     throughout; instr_valid rises the cycle after ack.
//  4. No ack for TIMEOUT (15) cycles -> fetch_err=1, imem_req=0. Later acks
//     and instr_ready ignored. reset_n=0 clears to pc=RESET_PC.
//  5. Ack on cycle 15 exactly (timer==TIMEOUT edge) -> fetch completes,
//     fetch_err=0.
//  6. reset_n=0 during HOLD with instr_ready=1 -> no count increment,
//     pc=RESET_PC, instr_valid=0.
//     pc_out=0xFFFF_FFFF_FFFF_FFFC, not taken -> next imem_addr=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage of the non-pipelined LEGv8 core. It owns the program counter,
// requests one instruction at a time from instruction memory with a req/ack
// handshake, and holds the fetched word and its address stable for decode
// until the core retires it. On retire, the next PC is either the
// sequential address (+4) or a branch target built from the sign-extended
// word offset. If memory fails to acknowledge within TIMEOUT request
// cycles, the unit parks in a sticky fault state until reset.
//
// Parameters
//   WORD       datapath / PC width
//   INSTR_LEN  instruction width
//   RESET_PC   PC loaded on reset
//   TIMEOUT    request cycles allowed without imem_ack before fault (>=1)
//
// Ports
//   clk            in   core clock, all state on rising edge
//   reset_n        in   synchronous active-low reset
//   imem_req       out  fetch request to instruction memory
//   imem_addr      out  fetch address, stable while imem_req=1
//   imem_ack       in   imem_rdata is valid this cycle
//   imem_rdata     in   fetched instruction word
//   instruction    out  instruction register feeding decode
//   pc_out         out  address of the instruction in the register
//   instr_valid    out  instruction/pc_out hold a live instruction
//   instr_ready    in   core has finished the current instruction
//   branch_taken   in   redirect request, only meaningful with instr_ready
//   branch_offset  in   sign-extended branch offset in words
//   fetch_err      out  sticky imem_ack timeout flag
//   instr_count    out  retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int              WORD      = 64,
  parameter int              INSTR_LEN = 32,
  parameter logic [WORD-1:0] RESET_PC  = '0,
  parameter int              TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 imem_req,
  output logic [WORD-1:0]      imem_addr,
  input  logic                 imem_ack,
  input  logic [INSTR_LEN-1:0] imem_rdata,
  output logic [INSTR_LEN-1:0] instruction,
  output logic [WORD-1:0]      pc_out,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 branch_taken,
  input  logic [WORD-1:0]      branch_offset,
  output logic                 fetch_err,
  output logic [WORD-1:0]      instr_count
);

  // The timer only ever holds 0..TIMEOUT-1: reaching TIMEOUT is the fault
  // event itself, so it never needs to be stored.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                 r_req;
  logic [WORD-1:0]      r_pc;
  logic [TW-1:0]        r_timer;
  logic [INSTR_LEN-1:0] r_instr;
  logic [WORD-1:0]      r_pc_out;
  logic                 r_valid;
  logic                 r_err;
  logic [WORD-1:0]      r_count;

  logic                 w_req_nxt;
  logic [TW-1:0]        w_timer_nxt;
  logic                 w_fetching;
  logic                 w_tmo;
  logic                 w_capture;
  logic                 w_retire;
  logic                 w_fault_set;
  logic signed [WORD-1:0] w_offset_s;
  logic [WORD-1:0]      w_seq_pc;
  logic [WORD-1:0]      w_branch_pc;
  logic [WORD-1:0]      w_pc_nxt;

  // A request is only live once r_req is up; the single FETCH cycle right
  // after reset release has r_req=0 and must not capture or count time.
  assign w_fetching = (r_state == S_FETCH) && r_req;
  assign w_tmo      = (r_timer == TMO_LAST);

  // Next-PC arithmetic is plain modulo-2^WORD; the shifted offset keeps the
  // target word-aligned since pc_out is always aligned.
  assign w_offset_s  = signed'(branch_offset);
  assign w_seq_pc    = r_pc_out + WORD'(4);
  assign w_branch_pc = r_pc_out + WORD'(w_offset_s <<< 2);
  assign w_pc_nxt    = branch_taken ? w_branch_pc : w_seq_pc;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: begin
        // An ack arriving on the last permitted cycle beats the timeout.
        if (w_fetching) begin
          if (imem_ack) begin
            w_state_nxt = S_HOLD;
          end else if (w_tmo) begin
            w_state_nxt = S_FAULT;
          end
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end
      default: begin
        w_state_nxt = S_FAULT;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath control logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_req_nxt   = 1'b0;
    w_timer_nxt = '0;
    w_capture   = 1'b0;
    w_retire    = 1'b0;
    w_fault_set = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_fetching) begin
          if (imem_ack) begin
            w_capture = 1'b1;
          end else if (w_tmo) begin
            w_fault_set = 1'b1;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
      end
      S_HOLD: begin
        w_retire = instr_ready;
      end
      default: begin
      end
    endcase
    // Request is registered so imem_addr and imem_req change together.
    w_req_nxt = (w_state_nxt == S_FETCH);
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_req    <= 1'b0;
      r_pc     <= RESET_PC;
      r_timer  <= '0;
      r_instr  <= '0;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_count  <= '0;
    end else begin
      r_req   <= w_req_nxt;
      r_timer <= w_timer_nxt;
      if (w_capture) begin
        r_instr  <= imem_rdata;
        r_pc_out <= r_pc;
        r_valid  <= 1'b1;
      end
      if (w_retire) begin
        r_valid <= 1'b0;
        r_count <= r_count + WORD'(1);
        r_pc    <= w_pc_nxt;
      end
      if (w_fault_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign instruction = r_instr;
  assign pc_out      = r_pc_out;
  assign instr_valid = r_valid;
  assign fetch_err   = r_err;
  assign instr_count = r_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [63:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [63:0] branch_offset;
  logic        fetch_err;
  logic [63:0] instr_count;

  instr_fetch_unit #(
    .WORD(64), .INSTR_LEN(32), .RESET_PC(64'h0), .TIMEOUT(15)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc_out(pc_out), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .fetch_err(fetch_err),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          delay;   // request cycles without ack before the ack
    int          hold;    // extra HOLD cycles before retire
    logic [31:0] rdata;
    logic        taken;
    logic [63:0] off;
    logic [63:0] pc;      // expected fetch address
    logic [63:0] nxt;     // expected next fetch address after retire
  } vec_t;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] instr;
  } exp_t;

  vec_t        vecs[11];
  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input int delay, input logic [31:0] data, input logic [63:0] addr);
    exp_t e;
    for (int i = 0; i < delay; i++) begin
      check("req_wait", 64'(imem_req), 64'd1);
      check("addr_wait", imem_addr, addr);
      instr_ready  = 1'b1;  // must be ignored while fetching
      branch_taken = 1'b1;
      tick();
    end
    check("req_ack", 64'(imem_req), 64'd1);
    check("addr_ack", imem_addr, addr);
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    imem_ack     = 1'b1;
    imem_rdata   = data;
    e.addr  = addr;
    e.instr = data;
    sbq.push_back(e);
    tick();
    imem_ack = 1'b0;
    check("valid_after_ack", 64'(instr_valid), 64'd1);
    check("req_in_hold", 64'(imem_req), 64'd0);
    if (instr_valid === 1'b1 && sbq.size() > 0) begin
      e = sbq.pop_front();
      check("sb_instr", 64'(instruction), 64'(e.instr));
      check("sb_pc_out", pc_out, e.addr);
    end
  endtask

  task automatic do_retire(input int hold, input logic taken, input logic [63:0] off,
                           input logic [63:0] nxt);
    logic [31:0] held;
    held = instruction;
    for (int i = 0; i < hold; i++) begin
      imem_ack   = 1'b1;   // must be ignored in HOLD
      imem_rdata = 32'hDEADBEEF;
      tick();
      check("hold_instr", 64'(instruction), 64'(held));
      check("hold_req", 64'(imem_req), 64'd0);
    end
    imem_ack      = 1'b0;
    instr_ready   = 1'b1;
    branch_taken  = taken;
    branch_offset = off;
    tick();
    instr_ready   = 1'b0;
    branch_taken  = 1'b0;
    exp_cnt       = exp_cnt + 64'd1;
    check("valid_after_retire", 64'(instr_valid), 64'd0);
    check("instr_count", instr_count, exp_cnt);
    check("req_after_retire", 64'(imem_req), 64'd1);
    check("next_addr", imem_addr, nxt);
  endtask

  initial begin
    vecs[0]  = '{0, 0, 32'h8B020020, 1'b0, 64'h0, 64'h0, 64'h4};
    vecs[1]  = '{0, 0, 32'h8B020020, 1'b0, 64'h0, 64'h4, 64'h8};
    vecs[2]  = '{0, 0, 32'h8B020020, 1'b0, 64'h0, 64'h8, 64'hC};
    vecs[3]  = '{0, 0, 32'h8B020020, 1'b0, 64'h0, 64'hC, 64'h10};
    vecs[4]  = '{1, 0, 32'h8B020020, 1'b1, 64'hC, 64'h10, 64'h40};
    vecs[5]  = '{3, 0, 32'hB4000040, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 64'h30};
    vecs[6]  = '{0, 2, 32'hD2800001, 1'b0, 64'h0, 64'h30, 64'h34};
    vecs[7]  = '{0, 0, 32'h14000000, 1'b1, 64'hFFFF_FFFF_FFFF_FFF3, 64'h34, 64'h0};
    vecs[8]  = '{2, 0, 32'hCB010000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[9]  = '{0, 0, 32'hAA0103E0, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
    vecs[10] = '{14, 0, 32'h91000421, 1'b1, 64'h4000_0000_0000_0001, 64'h0, 64'h4};

    reset_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h12345678;
    instr_ready = 1'b0; branch_taken = 1'b0; branch_offset = '0;
    tick();
    tick();
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_addr", imem_addr, 64'h0);
    check("rst_instr", 64'(instruction), 64'd0);
    check("rst_pc_out", pc_out, 64'h0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_err", 64'(fetch_err), 64'd0);
    check("rst_count", instr_count, 64'd0);

    imem_ack = 1'b0;
    reset_n  = 1'b1;
    tick();
    check("first_req", 64'(imem_req), 64'd1);
    check("first_valid", 64'(instr_valid), 64'd0);

    for (int k = 0; k < 11; k++) begin
      do_fetch(vecs[k].delay, vecs[k].rdata, vecs[k].pc);
      do_retire(vecs[k].hold, vecs[k].taken, vecs[k].off, vecs[k].nxt);
    end
    check("err_after_table", 64'(fetch_err), 64'd0);

    // Timeout: 14 silent request cycles are tolerated, the 15th faults.
    for (int i = 0; i < 14; i++) tick();
    check("tmo_err_before", 64'(fetch_err), 64'd0);
    check("tmo_req_before", 64'(imem_req), 64'd1);
    tick();
    check("tmo_err", 64'(fetch_err), 64'd1);
    check("tmo_req", 64'(imem_req), 64'd0);

    imem_ack = 1'b1; imem_rdata = 32'hCAFEF00D; instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    imem_ack = 1'b0; instr_ready = 1'b0;
    check("fault_err", 64'(fetch_err), 64'd1);
    check("fault_req", 64'(imem_req), 64'd0);
    check("fault_valid", 64'(instr_valid), 64'd0);
    check("fault_instr", 64'(instruction), 64'h91000421);
    check("fault_addr", imem_addr, 64'h4);
    check("fault_count", instr_count, exp_cnt);

    reset_n = 1'b0;
    tick();
    exp_cnt = 0;
    check("frst_err", 64'(fetch_err), 64'd0);
    check("frst_addr", imem_addr, 64'h0);
    check("frst_count", instr_count, 64'd0);
    reset_n = 1'b1;
    tick();
    check("frst_req", 64'(imem_req), 64'd1);

    // Reset during HOLD with a simultaneous retire request.
    do_fetch(0, 32'h8B020020, 64'h0);
    do_retire(0, 1'b0, 64'h0, 64'h4);
    do_fetch(1, 32'hF8400020, 64'h4);
    reset_n     = 1'b0;
    instr_ready = 1'b1;
    tick();
    reset_n     = 1'b1;
    instr_ready = 1'b0;
    check("hrst_count", instr_count, 64'd0);
    check("hrst_valid", 64'(instr_valid), 64'd0);
    check("hrst_addr", imem_addr, 64'h0);
    check("hrst_req", 64'(imem_req), 64'd0);
    check("hrst_pc_out", pc_out, 64'h0);
    tick();
    check("hrst_req_after", 64'(imem_req), 64'd1);
    check("hrst_addr_after", imem_addr, 64'h0);

    check("sb_empty", 64'(sbq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
